// File: rtl/fp_rs_pkg.sv
// ============================================================================
// Module   : fp_rs_pkg
// Purpose  : Shared types and constants for the FP add/sub reservation station
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_rs_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int   EXP_W  = 11;
  localparam int   MAN_W  = 52;
  localparam int   DW     = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic          busy;
    logic          op;
    logic          qj_pend;
    logic          qk_pend;
    logic [DW-1:0] vj;
    logic [DW-1:0] vk;
  } rs_entry_t;
endpackage

`default_nettype wire

// File: rtl/fp_rs_select.sv
// ============================================================================
// Module   : fp_rs_select
// Purpose  : Lowest-index priority encoder over a request vector
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_rs_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    o_found = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_addsub_rs.sv
// ============================================================================
// Module   : fp_addsub_rs
// Purpose  : Reservation station feeding the double-precision add/sub datapath
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_addsub_rs
  import fp_rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_op,
  input  logic [TAG_W-1:0] disp_dest,
  input  logic [DW-1:0]    disp_vj,
  input  logic [DW-1:0]    disp_vk,
  input  logic             disp_qj_pend,
  input  logic             disp_qk_pend,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [DW-1:0]    cdb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic             ex_sa,
  output logic             ex_sb,
  output logic [EXP_W-1:0] ex_ea,
  output logic [EXP_W-1:0] ex_eb,
  output logic [MAN_W-1:0] ex_ma,
  output logic [MAN_W-1:0] ex_mb,
  output logic [TAG_W-1:0] ex_tag
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  rs_entry_t        r_ent  [NUM_ENTRIES];
  logic [TAG_W-1:0] r_dest [NUM_ENTRIES];
  logic [TAG_W-1:0] r_qj   [NUM_ENTRIES];
  logic [TAG_W-1:0] r_qk   [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] w_free;
  logic [NUM_ENTRIES-1:0] w_rdy;
  logic                   w_free_found;
  logic                   w_rdy_found;
  logic [IDX_W-1:0]       w_free_idx;
  logic [IDX_W-1:0]       w_rdy_idx;
  logic                   w_disp_fire;
  logic                   w_issue;
  logic                   w_fwd_j;
  logic                   w_fwd_k;
  rs_entry_t              w_sel;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_free[i] = ~r_ent[i].busy;
      w_rdy[i]  = r_ent[i].busy & ~r_ent[i].qj_pend & ~r_ent[i].qk_pend;
    end
  end

  fp_rs_select #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_free_sel (
    .i_req   (w_free),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  fp_rs_select #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_rdy_sel (
    .i_req   (w_rdy),
    .o_found (w_rdy_found),
    .o_idx   (w_rdy_idx)
  );

  assign disp_ready  = w_free_found;
  assign w_disp_fire = disp_valid & w_free_found;
  assign w_issue     = w_rdy_found & (~ex_valid | ex_ready);
  assign w_fwd_j     = disp_qj_pend & cdb_valid & (cdb_tag == disp_qj);
  assign w_fwd_k     = disp_qk_pend & cdb_valid & (cdb_tag == disp_qk);
  assign w_sel       = r_ent[w_rdy_idx];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_ent[i].busy    <= 1'b0;
        r_ent[i].qj_pend <= 1'b0;
        r_ent[i].qk_pend <= 1'b0;
      end
      ex_valid <= 1'b0;
      ex_sa    <= 1'b0;
      ex_sb    <= 1'b0;
      ex_ea    <= '0;
      ex_eb    <= '0;
      ex_ma    <= '0;
      ex_mb    <= '0;
      ex_tag   <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (r_ent[i].busy && r_ent[i].qj_pend && cdb_valid && (r_qj[i] == cdb_tag)) begin
          r_ent[i].vj      <= cdb_data;
          r_ent[i].qj_pend <= 1'b0;
        end
        if (r_ent[i].busy && r_ent[i].qk_pend && cdb_valid && (r_qk[i] == cdb_tag)) begin
          r_ent[i].vk      <= cdb_data;
          r_ent[i].qk_pend <= 1'b0;
        end
        if (w_issue && (w_rdy_idx == IDX_W'(i))) r_ent[i].busy <= 1'b0;
        // Dispatch targets only free entries, so it never collides with snoop or issue.
        if (w_disp_fire && (w_free_idx == IDX_W'(i))) begin
          r_ent[i].busy    <= 1'b1;
          r_ent[i].op      <= disp_op;
          r_ent[i].qj_pend <= disp_qj_pend & ~w_fwd_j;
          r_ent[i].qk_pend <= disp_qk_pend & ~w_fwd_k;
          r_ent[i].vj      <= w_fwd_j ? cdb_data : disp_vj;
          r_ent[i].vk      <= w_fwd_k ? cdb_data : disp_vk;
          r_dest[i]        <= disp_dest;
          r_qj[i]          <= disp_qj;
          r_qk[i]          <= disp_qk;
        end
      end

      if (w_issue) begin
        ex_valid <= 1'b1;
        ex_sa    <= w_sel.vj[DW-1];
        ex_ea    <= w_sel.vj[DW-2 -: EXP_W];
        ex_ma    <= w_sel.vj[MAN_W-1:0];
        // The datapath always subtracts; an add flips the sign of b.
        ex_sb    <= w_sel.vk[DW-1] ^ (w_sel.op == OP_ADD);
        ex_eb    <= w_sel.vk[DW-2 -: EXP_W];
        ex_mb    <= w_sel.vk[MAN_W-1:0];
        ex_tag   <= r_dest[w_rdy_idx];
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
